// File: rtl/rat_io_responder_if.sv
// CPU port bus between the control unit / register file and the I/O
// responder. master = CPU side, slave = responder side.
//   RIO_PORT_ID  : port address for IN/OUT
//   RIO_OUT_DATA : OUT write data
//   RIO_IO_STRB  : one-cycle OUT write strobe
//   RIO_IN_DATA  : IN read data back to the CPU
interface rat_io_responder_if;
    logic [7:0] RIO_PORT_ID;
    logic [7:0] RIO_OUT_DATA;
    logic       RIO_IO_STRB;
    logic [7:0] RIO_IN_DATA;

    modport master (
        output RIO_PORT_ID,
        output RIO_OUT_DATA,
        output RIO_IO_STRB,
        input  RIO_IN_DATA
    );

    modport slave (
        input  RIO_PORT_ID,
        input  RIO_OUT_DATA,
        input  RIO_IO_STRB,
        output RIO_IN_DATA
    );
endinterface

// File: rtl/rat_io_responder.sv
// RAT board I/O responder: synchronized switches, debounced buttons with
// a pending/mask interrupt controller, LED and seven-segment registers.
// Ports:
//   RIO_CLK, RIO_RST   : clock, async active-high reset
//   bus (slave)        : CPU port bus (id, out data, strobe, in data)
//   RIO_SWITCHES[7:0]  : async switches
//   RIO_BUTTONS[3:0]   : async bouncing buttons
//   RIO_LEDS[7:0]      : LED register      (OUT 0x40)
//   RIO_SSEG_VAL[7:0]  : 7-seg register    (OUT 0x81)
//   RIO_INT            : |(pending & mask)
// Read map: 0x20 switches, 0x24 buttons, 0x25 pending, 0x26 mask.
// Write map: 0x40 leds, 0x81 sseg, 0x26 mask, 0x25 pending W1C.
// Build option: define RIO_DEBOUNCE_EN to build the DB_CYCLES debouncers;
// otherwise each button bit is just re-registered after the synchronizer.
module rat_io_responder #(
    parameter int unsigned DB_CYCLES = 10000
) (
    input  logic               RIO_CLK,
    input  logic               RIO_RST,
    rat_io_responder_if.slave  bus,
    input  logic [7:0]         RIO_SWITCHES,
    input  logic [3:0]         RIO_BUTTONS,
    output logic [7:0]         RIO_LEDS,
    output logic [7:0]         RIO_SSEG_VAL,
    output logic               RIO_INT
);

    localparam logic [7:0] ID_SW   = 8'h20;
    localparam logic [7:0] ID_BTN  = 8'h24;
    localparam logic [7:0] ID_PEND = 8'h25;
    localparam logic [7:0] ID_MASK = 8'h26;
    localparam logic [7:0] ID_LEDS = 8'h40;
    localparam logic [7:0] ID_SSEG = 8'h81;

    logic [7:0] sw_s1, sw_s2;
    logic [3:0] btn_s1, btn_s2;
    logic [3:0] btn_db;
    logic [3:0] btn_db_q;
    logic [3:0] mask;
    logic [3:0] pending;
    logic [3:0] pend_set;
    logic [3:0] pend_clr;
    logic [3:0] pend_nxt;

    logic wr_leds, wr_sseg, wr_mask, wr_pend;

    // Two-flop synchronizers on all board inputs.
    always_ff @(posedge RIO_CLK or posedge RIO_RST) begin
        if (RIO_RST) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= RIO_SWITCHES;
            sw_s2  <= sw_s1;
            btn_s1 <= RIO_BUTTONS;
            btn_s2 <= btn_s1;
        end
    end

`ifdef RIO_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [15:0] db_cnt [4];

    // A counter runs only while the synced input disagrees with the
    // debounced state; the DB_CYCLES-th disagreeing edge flips the state.
    always_ff @(posedge RIO_CLK or posedge RIO_RST) begin
        if (RIO_RST) begin
            btn_db <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] != btn_db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_db[i] <= btn_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_db_cycles;
    assign unused_db_cycles = ^DB_CYCLES;

    always_ff @(posedge RIO_CLK or posedge RIO_RST) begin
        if (RIO_RST) begin
            btn_db <= '0;
        end else begin
            btn_db <= btn_s2;
        end
    end
`endif

    assign wr_leds = bus.RIO_IO_STRB && (bus.RIO_PORT_ID == ID_LEDS);
    assign wr_sseg = bus.RIO_IO_STRB && (bus.RIO_PORT_ID == ID_SSEG);
    assign wr_mask = bus.RIO_IO_STRB && (bus.RIO_PORT_ID == ID_MASK);
    assign wr_pend = bus.RIO_IO_STRB && (bus.RIO_PORT_ID == ID_PEND);

    // Rising edge of a debounced bit, seen one edge after it lands.
    assign pend_set = btn_db & ~btn_db_q;
    assign pend_clr = wr_pend ? bus.RIO_OUT_DATA[3:0] : 4'h0;

    // Set is ORed in after the clear so a colliding set wins.
    always_comb begin
        pend_nxt = (pending & ~pend_clr) | pend_set;
    end

    always_ff @(posedge RIO_CLK or posedge RIO_RST) begin
        if (RIO_RST) begin
            btn_db_q     <= '0;
            pending      <= '0;
            mask         <= '0;
            RIO_LEDS     <= '0;
            RIO_SSEG_VAL <= '0;
        end else begin
            btn_db_q <= btn_db;
            pending  <= pend_nxt;
            if (wr_mask) begin
                mask <= bus.RIO_OUT_DATA[3:0];
            end
            if (wr_leds) begin
                RIO_LEDS <= bus.RIO_OUT_DATA;
            end
            if (wr_sseg) begin
                RIO_SSEG_VAL <= bus.RIO_OUT_DATA;
            end
        end
    end

    assign RIO_INT = |(pending & mask);

    always_comb begin
        bus.RIO_IN_DATA = 8'h00;
        case (bus.RIO_PORT_ID)
            ID_SW:   bus.RIO_IN_DATA = sw_s2;
            ID_BTN:  bus.RIO_IN_DATA = {4'h0, btn_db};
            ID_PEND: bus.RIO_IN_DATA = {4'h0, pending};
            ID_MASK: bus.RIO_IN_DATA = {4'h0, mask};
            default: bus.RIO_IN_DATA = 8'h00;
        endcase
    end

endmodule

// File: doc/rat_io_responder.md
RAT_IO_RESPONDER -- requirements
Module: rat_io_responder

Interface
REQ-001 Parameter: DB_CYCLES, default 10000, debounce stable-cycle count (1..65535).
REQ-002 RIO_CLK  in  1  system clock; all state on its rising edge.
REQ-003 RIO_RST  in  1  reset; asynchronous, active-high.
REQ-004 RIO_PORT_ID  in  8  port address from the CPU for IN/OUT.
REQ-005 RIO_OUT_DATA  in  8  write data from the CPU register file.
REQ-006 RIO_IO_STRB  in  1  one-cycle write strobe issued by the control unit during OUT.
REQ-007 RIO_IN_DATA  out  8  read data returned to the CPU for IN.
REQ-008 RIO_SWITCHES  in  8  asynchronous board switches.
REQ-009 RIO_BUTTONS  in  4  asynchronous, bouncing board buttons.
REQ-010 RIO_LEDS  out  8  LED register.
REQ-011 RIO_SSEG_VAL  out  8  seven-segment value register.
REQ-012 RIO_INT  out  1  level interrupt request to the control unit.

Function
REQ-013 The block SHALL pass RIO_SWITCHES and RIO_BUTTONS through 2-flop synchronizers before any use.
REQ-014 RIO_IN_DATA SHALL be a combinational decode of RIO_PORT_ID: 0x20 sync switches; 0x24 {4'b0, debounced buttons}; 0x25 {4'b0, pending}; 0x26 {4'b0, mask}; any other ID 0x00.
REQ-015 On an edge with RIO_IO_STRB=1, the block SHALL write: ID 0x40 -> LEDS; 0x81 -> SSEG_VAL; 0x26 -> mask = OUT_DATA[3:0]; 0x25 -> clear each pending bit whose OUT_DATA[3:0] bit is 1 (write-1-to-clear).
REQ-016 Writes to unmapped IDs SHALL have no effect; with RIO_IO_STRB=0, no register SHALL change due to the port bus.
REQ-017 A written value SHALL be visible on outputs/readback in the cycle after the strobe edge.
REQ-018 Each button SHALL have an independent 16-bit debounce counter: counts up while the synchronized input differs from the debounced state, and resets to 0 when they agree.
REQ-019 The debounced bit SHALL take the synchronized value on the edge that completes DB_CYCLES consecutive disagreeing cycles; its counter SHALL return to 0 on that same edge.
REQ-020 A 0->1 transition of a debounced bit SHALL set the matching pending bit on the following edge; 1->0 transitions SHALL set nothing.
REQ-021 If a W1C clear and a set hit the same pending bit in the same cycle, the set SHALL win.
REQ-022 RIO_INT SHALL equal the OR of (pending AND mask), combinationally from registers, with no added latency.
REQ-023 Changing the mask SHALL NOT alter pending bits; masked pending bits SHALL remain readable at 0x25.
REQ-024 Switch-to-IN latency SHALL be 2 cycles.
REQ-025 Button-press-to-pending latency SHALL be 2 + DB_CYCLES + 1 cycles for a clean edge.

Reset
REQ-026 While RIO_RST=1, all of the following SHALL be 0: LEDS, SSEG_VAL, mask, pending, debounced buttons, debounce counters, and synchronizer flops. RIO_INT=0.
REQ-027 Assertion of RIO_RST mid-debounce SHALL discard the partial count; after release, counting SHALL restart from 0.
REQ-028 The first edge after RIO_RST deasserts SHALL behave as a normal operating cycle.

Configuration
REQ-029 Macro RIO_DEBOUNCE_EN SHALL control debounce.
- Defined: debounce per REQ-018..019.
- Undefined: counters are not built; the debounced bit SHALL be a register loaded from the synchronized bit every cycle. Press-to-pending latency becomes 4 cycles; DB_CYCLES is ignored.

Verification (bench uses DB_CYCLES=4, RIO_DEBOUNCE_EN defined unless stated)
REQ-030 Reset, then SWITCHES=0xA5, wait 2 cycles, PORT_ID=0x20 -> IN_DATA=0xA5; PORT_ID=0x33 -> 0x00.
REQ-031 OUT 0x40 data 0x3C with STRB for 1 cycle -> LEDS=0x3C next cycle; same ID/data with STRB=0 -> LEDS unchanged.
REQ-032 mask=0x1, BUTTONS[0] held high -> pending=0x1 and INT=1 exactly 7 cycles after the press. BUTTONS[0] pulsed for 3 cycles -> no pending bit set.
REQ-033 Pending=0x1: W1C 0x25 with 0x1 -> pending=0 and INT=0. Clear issued in the same cycle as a new set of bit 0 -> pending stays 0x1.
REQ-034 Pending=0x2 with mask=0x0 -> INT=0, IN 0x25 reads 0x02; write mask 0x2 -> INT=1 next cycle.
REQ-035 Assert RIO_RST while a button count is 2 -> all outputs 0; after release with the button held, pending sets 7 cycles later. With the macro undefined, pending sets 4 cycles after the press.
